// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the memory-stage initiator (master) and dmem (slave).
interface dmem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            dmem_read;
  logic [2:0]            dmem_write;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [31:0]           dmem_writedata;
  logic [31:0]           dmem_readdata;
  logic                  dmem_busywait;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_writedata,
    input  dmem_readdata, dmem_busywait
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_writedata,
    output dmem_readdata, dmem_busywait
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store initiator: checks legality/alignment, issues one dmem access and stalls until done.
// Optional busywait timeout abort is enabled with `define DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            mem_read,
  input  logic [2:0]            mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  misalign,
  output logic                  cmd_error,
  output logic                  bus_error,
  dmem_access_ctrl_if.master    dmem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state;
  logic [3:0]            rd_cmd_p1;
  logic [2:0]            wr_cmd_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [31:0]           wdata_p1;

  logic       ld_en, st_en, req, both_en;
  logic       ld_illegal, st_illegal, cmd_bad, misal, legal;
  logic [1:0] acc_size;

  // Request decode: legality first, then alignment of the access size
  assign ld_en      = mem_read[3];
  assign st_en      = mem_write[2];
  assign both_en    = ld_en & st_en;
  assign req        = ld_en ^ st_en;
  assign ld_illegal = ld_en & ((mem_read[2:0] == 3'b011) | (mem_read[2:0] == 3'b110) |
                               (mem_read[2:0] == 3'b111));
  assign st_illegal = st_en & (mem_write[1:0] == 2'b11);
  assign cmd_bad    = both_en | (req & (ld_illegal | st_illegal));
  assign acc_size   = ld_en ? mem_read[1:0] : mem_write[1:0];
  assign misal      = req & ~cmd_bad &
                      (((acc_size == 2'b01) & mem_addr[0]) |
                       ((acc_size == 2'b10) & (mem_addr[1:0] != 2'b00)));
  assign legal      = req & ~cmd_bad & ~misal;

  // Holding in IDLE is combinational so the pipeline freezes on the accepting edge
  assign stall = reset & (((state == IDLE) & legal) | (state == ISSUE) | (state == WAIT));

  assign dmem.dmem_read      = rd_cmd_p1;
  assign dmem.dmem_write     = wr_cmd_p1;
  assign dmem.dmem_address   = addr_p1;
  assign dmem.dmem_writedata = wdata_p1;

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          bus_error_p1;
  assign bus_error = bus_error_p1;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_cmd_p1 <= '0;
      wr_cmd_p1 <= '0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      load_data <= '0;
      misalign  <= 1'b0;
      cmd_error <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      to_cnt       <= '0;
      bus_error_p1 <= 1'b0;
`endif
    end else begin
      misalign  <= 1'b0;
      cmd_error <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_error_p1 <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          cmd_error <= cmd_bad;
          misalign  <= misal;
          if (legal) begin
            rd_cmd_p1 <= ld_en ? mem_read  : 4'b0000;
            wr_cmd_p1 <= st_en ? mem_write : 3'b000;
            addr_p1   <= mem_addr;
            wdata_p1  <= mem_wdata;
            state     <= ISSUE;
          end
        end
        // dmem samples on the negedge of ISSUE, so busywait is only meaningful from WAIT on
        ISSUE: begin
`ifdef DMEM_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (!dmem.dmem_busywait) begin
            if (rd_cmd_p1[3]) load_data <= dmem.dmem_readdata;
            rd_cmd_p1 <= '0;
            wr_cmd_p1 <= '0;
            state     <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (int'(to_cnt) + 1 >= TIMEOUT_CYCLES) begin
            rd_cmd_p1    <= '0;
            wr_cmd_p1    <= '0;
            load_data    <= '0;
            bus_error_p1 <= 1'b1;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed + randomized bench for dmem_access_ctrl with a byte-array dmem device and a reference model.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;
  logic        stall, misalign, cmd_error, bus_error;

  int checks   = 0;
  int failures = 0;
  int dev_lat  = 0;

  logic [7:0]  ref_mem [256];
  logic [7:0]  dev_mem [256];
  logic [31:0] exp_load = 32'h0;

  dmem_access_ctrl_if #(.ADDR_WIDTH(32)) dif ();

  dmem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .load_data (load_data),
    .stall     (stall),
    .misalign  (misalign),
    .cmd_error (cmd_error),
    .bus_error (bus_error),
    .dmem      (dif)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 legal, 1 command error, 2 misaligned, 3 no request
  function automatic int classify(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a);
    int nbytes;
    if (!rd[3] && !wr[2]) return 3;
    if (rd[3] && wr[2]) return 1;
    if (rd[3]) begin
      if (rd[2:0] inside {3'd3, 3'd6, 3'd7}) return 1;
      nbytes = 1 << rd[1:0];
    end else begin
      if (wr[1:0] == 2'd3) return 1;
      nbytes = 1 << wr[1:0];
    end
    if ((a % nbytes) != 0) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int    n = 1 << f3[1:0];
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // dmem device: samples a new command on the negedge, busy for dev_lat posedges
  initial begin
    logic       prev_en = 1'b0;
    logic       en;
    int         rem = 0;
    logic [7:0] a, base;
    logic [31:0] w, sh;
    dif.dmem_busywait = 1'b0;
    dif.dmem_readdata = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        dif.dmem_busywait = 1'b0;
        prev_en = 1'b0;
        rem = 0;
      end else begin
        en = dif.dmem_read[3] | dif.dmem_write[2];
        if (en && !prev_en) begin
          a = dif.dmem_address[7:0];
          if (dif.dmem_write[2]) begin
            dev_mem[a] = dif.dmem_writedata[7:0];
            if (dif.dmem_write[1:0] != 2'b00) dev_mem[a + 8'd1] = dif.dmem_writedata[15:8];
            if (dif.dmem_write[1:0] == 2'b10) begin
              dev_mem[a + 8'd2] = dif.dmem_writedata[23:16];
              dev_mem[a + 8'd3] = dif.dmem_writedata[31:24];
            end
          end else begin
            base = {a[7:2], 2'b00};
            w  = {dev_mem[base + 8'd3], dev_mem[base + 8'd2], dev_mem[base + 8'd1], dev_mem[base]};
            sh = w >> (8 * a[1:0]);
            case (dif.dmem_read[2:0])
              3'b000:  dif.dmem_readdata = {{24{sh[7]}}, sh[7:0]};
              3'b001:  dif.dmem_readdata = {{16{sh[15]}}, sh[15:0]};
              3'b100:  dif.dmem_readdata = {24'h0, sh[7:0]};
              3'b101:  dif.dmem_readdata = {16'h0, sh[15:0]};
              default: dif.dmem_readdata = w;
            endcase
          end
          if (dev_lat > 0) begin
            dif.dmem_busywait = 1'b1;
            rem = dev_lat;
          end
        end else if (dif.dmem_busywait) begin
          rem--;
          if (rem <= 0) dif.dmem_busywait = 1'b0;
        end
        prev_en = en;
      end
    end
  end

  task automatic set_idle();
    mem_read  = 4'b0000;
    mem_write = 3'b000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  // Entered and left #1 after a posedge with the controller in IDLE
  task automatic access(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    int kind = classify(rd, wr, a);
    int nst = 0, nen = 0, exp_st;
    dev_lat   = lat;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = wd;
    @(negedge clock);
    if (kind != 0) begin
      check({tag, ".stall_idle"}, 32'(stall), 32'd0);
      @(posedge clock); #1;
      set_idle();
      @(negedge clock);
      check({tag, ".cmd_error"}, 32'(cmd_error), 32'(kind == 1));
      check({tag, ".misalign"}, 32'(misalign), 32'(kind == 2));
      check({tag, ".no_cmd"}, {25'h0, dif.dmem_read, dif.dmem_write}, 32'h0);
      @(posedge clock); #1;
      @(negedge clock);
      check({tag, ".pulse_end"}, {30'h0, cmd_error, misalign}, 32'h0);
      @(posedge clock); #1;
    end else begin
      if (rd[3]) exp_load = ref_load(rd[2:0], a);
      else       ref_store(wr[1:0], a, wd);
      exp_st = 3 + ((lat > 0) ? lat - 1 : 0);
      while (stall === 1'b1 && nst < 300) begin
        nst++;
        if (dif.dmem_read[3] || dif.dmem_write[2]) nen++;
        if (nst == 2) begin
          check({tag, ".dmem_read"}, 32'(dif.dmem_read), rd[3] ? 32'(rd) : 32'h0);
          check({tag, ".dmem_write"}, 32'(dif.dmem_write), wr[2] ? 32'(wr) : 32'h0);
          check({tag, ".dmem_address"}, dif.dmem_address, a);
          if (wr[2]) check({tag, ".dmem_writedata"}, dif.dmem_writedata, wd);
        end
        @(posedge clock); #1;
        if (nst == 1) begin
          mem_read  = 4'($urandom);
          mem_write = 3'($urandom);
          mem_addr  = $urandom;
          mem_wdata = $urandom;
        end
        @(negedge clock);
      end
      check({tag, ".stall_cycles"}, nst, exp_st);
      check({tag, ".cmd_cycles"}, nen, exp_st - 1);
      check({tag, ".load_data"}, load_data, exp_load);
      check({tag, ".done_idle_cmd"}, {25'h0, dif.dmem_read, dif.dmem_write}, 32'h0);
      check({tag, ".bus_error"}, 32'(bus_error), 32'h0);
      @(posedge clock); #1;
      set_idle();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".load_data"}, load_data, 32'h0);
    check({tag, ".flags"}, {28'h0, stall, misalign, cmd_error, bus_error}, 32'h0);
    check({tag, ".dmem_cmd"}, {25'h0, dif.dmem_read, dif.dmem_write}, 32'h0);
    check({tag, ".dmem_address"}, dif.dmem_address, 32'h0);
    check({tag, ".dmem_writedata"}, dif.dmem_writedata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h0;
      dev_mem[i] = 8'h0;
    end
    reset = 1'b0;
    set_idle();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    access("sw_10",   4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 0);
    access("lw_10",   4'b1010, 3'b000, 32'h10, 32'h0, 0);
    access("sb_10",   4'b0000, 3'b100, 32'h10, 32'h00000080, 1);
    access("lb_10",   4'b1000, 3'b000, 32'h10, 32'h0, 0);
    access("lbu_10",  4'b1100, 3'b000, 32'h10, 32'h0, 2);
    access("lw_12",   4'b1010, 3'b000, 32'h12, 32'h0, 0);
    access("lh_13",   4'b1001, 3'b000, 32'h13, 32'h0, 0);
    access("sw_21",   4'b0000, 3'b110, 32'h21, 32'h55, 0);
    access("both",    4'b1010, 3'b110, 32'h10, 32'h0, 0);
    access("both_ill",4'b1011, 3'b110, 32'h10, 32'h0, 0);
    access("ld_f011", 4'b1011, 3'b000, 32'h01, 32'h0, 0);
    access("st_sz11", 4'b0000, 3'b111, 32'h10, 32'h0, 0);
    access("lw_busy5",4'b1010, 3'b000, 32'h10, 32'h0, 5);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      rd = 4'b0000;
      wr = 3'b000;
      if (r < 4)      rd = {1'b1, 3'($urandom)};
      else if (r < 8) wr = {1'b1, 2'($urandom)};
      else if (r == 8) begin
        rd = {1'b1, 3'($urandom)};
        wr = {1'b1, 2'($urandom)};
      end
      sz = rd[3] ? rd[1:0] : wr[1:0];
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access($sformatf("rnd%0d", n), rd, wr, a, $urandom, int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a long load
    dev_lat   = 20;
    mem_read  = 4'b1010;
    mem_write = 3'b000;
    mem_addr  = 32'h10;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_wait");
    set_idle();
    exp_load = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    access("sh_20",  4'b0000, 3'b101, 32'h20, 32'h00001234, 2);
    access("lhu_20", 4'b1101, 3'b000, 32'h20, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
